// File: rtl/adaptive_sample_timer_pkg.sv
// Shared definitions for the adaptive sample timer and its neighbouring
// period-measurement stage: state encoding and default widths.
package adaptive_sample_timer_pkg;

    localparam int PERIOD_W_DEFAULT = 32;

    // The divisor never exceeds 255, so one extra bit holds the shifted partial remainder
    localparam int DIV_REM_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_APPLY = 2'd2
    } timer_state_e;

endpackage

// File: rtl/adaptive_sample_timer_if.sv
// Bundle of the timer's measurement input, enable and strobe/status outputs.
interface adaptive_sample_timer_if
    import adaptive_sample_timer_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEFAULT
);
    logic [PERIOD_W-1:0] period_in;
    logic                enable;
    logic                sample_strobe;
    logic [7:0]          sample_idx;
    logic [PERIOD_W-1:0] interval;
    logic                locked;
    logic                busy;
    logic                out_of_range;

    modport master (
        output period_in, enable,
        input  sample_strobe, sample_idx, interval, locked, busy, out_of_range
    );

    modport slave (
        input  period_in, enable,
        output sample_strobe, sample_idx, interval, locked, busy, out_of_range
    );
endinterface

// File: rtl/adaptive_sample_timer_divider.sv
// Multi-cycle restoring divider by a constant: one quotient bit per cycle,
// MSB first, with a one-cycle done pulse once all WIDTH bits are produced.
module seq_const_divider
    import adaptive_sample_timer_pkg::*;
#(
    parameter int WIDTH   = PERIOD_W_DEFAULT,
    parameter int DIVISOR = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_REM_W-1:0] DIVISOR_R = DIV_REM_W'(DIVISOR);

    logic [DIV_REM_W-1:0] rem_q, rem_d, trial;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // The quotient register doubles as the dividend shift register
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        trial  = (rem_q << 1) | DIV_REM_W'(quo_q[WIDTH-1]);
        if (start && !busy_q) begin
            rem_d  = '0;
            quo_d  = dividend;
            cnt_d  = CNT_W'(WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial >= DIVISOR_R) begin
                rem_d = trial - DIVISOR_R;
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = trial;
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/adaptive_sample_timer.sv
// Turns a measured signal period into a sample-strobe interval giving
// SAMPLES_PER_PERIOD strobes per period, plus a wrapping sample index.
module adaptive_sample_timer
    import adaptive_sample_timer_pkg::*;
#(
    parameter int PERIOD_W           = PERIOD_W_DEFAULT,
    parameter int SAMPLES_PER_PERIOD = 64,
    parameter int MIN_PERIOD         = 256,
    parameter int MAX_PERIOD         = 100000000,
    parameter int MIN_INTERVAL       = 2
) (
    input logic                    clk,
    input logic                    reset,
    adaptive_sample_timer_if.slave bus
);
    timer_state_e        state_q, state_d;
    logic [PERIOD_W-1:0] last_q, last_d;
    logic [PERIOD_W-1:0] interval_q, interval_d;
    logic [PERIOD_W-1:0] tick_q, tick_d;
    logic [7:0]          idx_q, idx_d;
    logic                locked_q, locked_d;
    logic                oor_q, oor_d;

    logic                div_start, div_busy, div_done;
    logic [PERIOD_W-1:0] div_quotient;
    logic                in_range, running, strobe;

    seq_const_divider #(
        .WIDTH   (PERIOD_W),
        .DIVISOR (SAMPLES_PER_PERIOD)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (bus.period_in),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    assign in_range = (bus.period_in >= PERIOD_W'(MIN_PERIOD)) &&
                      (bus.period_in <= PERIOD_W'(MAX_PERIOD));

    // Period changes are only sampled in IDLE, so a burst of updates during a division collapses to the latest
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        interval_d = interval_q;
        locked_d   = locked_q;
        oor_d      = 1'b0;
        div_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.period_in != last_q) begin
                    last_d = bus.period_in;
                    if (in_range && !div_busy) begin
                        div_start = 1'b1;
                        state_d   = ST_DIV;
                    end else begin
                        oor_d    = 1'b1;
                        locked_d = 1'b0;
                    end
                end
            end
            ST_DIV: begin
                if (div_done) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                interval_d = (div_quotient < PERIOD_W'(MIN_INTERVAL)) ?
                             PERIOD_W'(MIN_INTERVAL) : div_quotient;
                locked_d   = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A reload reads the interval register before this edge's APPLY write lands
    always_comb begin
        running = bus.enable && locked_q;
        strobe  = running && (tick_q == '0);
        tick_d  = tick_q;
        idx_d   = idx_q;
        if (!running) begin
            tick_d = '0;
            idx_d  = '0;
        end else if (strobe) begin
            tick_d = interval_q - PERIOD_W'(1);
            idx_d  = (idx_q == 8'(SAMPLES_PER_PERIOD - 1)) ? 8'd0 : idx_q + 8'd1;
        end else begin
            tick_d = tick_q - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            last_q     <= '0;
            interval_q <= '0;
            locked_q   <= 1'b0;
            oor_q      <= 1'b0;
            tick_q     <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            interval_q <= interval_d;
            locked_q   <= locked_d;
            oor_q      <= oor_d;
            tick_q     <= tick_d;
            idx_q      <= idx_d;
        end
    end

    assign bus.sample_strobe = strobe;
    assign bus.sample_idx    = idx_q;
    assign bus.interval      = interval_q;
    assign bus.locked        = locked_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.out_of_range  = oor_q;

endmodule
